// File: rtl/tc_result_writeback.sv
// Tensor-core result writeback: buffers one SHAPE_M x SHAPE_N tile and replays it
// to the vector register file as NUM_THREAD-lane beats on consecutive registers.

module tc_wb_lane #(
  parameter int ELEMS      = 64,
  parameter int ELEM_W     = 8,
  parameter int NUM_THREAD = 8,
  parameter int CNT_W      = 3,
  parameter int LANE       = 0
) (
  input  logic [ELEMS-1:0][ELEM_W-1:0] tile_data,
  input  logic [ELEMS-1:0]             tile_mask,
  input  logic [CNT_W-1:0]             cnt,
  output logic [ELEM_W-1:0]            data,
  output logic                         mask
);
  localparam int IDX_W = $clog2(ELEMS);

  // Lane l of beat k carries element k*NUM_THREAD + l.
  logic [IDX_W-1:0] idx;
  assign idx  = IDX_W'(cnt) * IDX_W'(NUM_THREAD) + IDX_W'(LANE);
  assign data = tile_data[idx];
  assign mask = tile_mask[idx];
endmodule

module tc_result_writeback #(
  parameter int SHAPE_M    = 8,
  parameter int SHAPE_N    = 8,
  parameter int ELEM_W     = 8,
  parameter int NUM_THREAD = 8,
  parameter int DEPTH_WARP = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [SHAPE_M*SHAPE_N*ELEM_W-1:0] result_i,
  input  logic [SHAPE_M*SHAPE_N*5-1:0]      fflags_i,
  input  logic [SHAPE_M*SHAPE_N-1:0]        elem_mask_i,
  input  logic [7:0]                        reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]             warpid_i,
  output logic                              wb_valid_o,
  input  logic                              wb_ready_i,
  output logic [NUM_THREAD*ELEM_W-1:0]      wb_data_o,
  output logic [NUM_THREAD-1:0]             wb_mask_o,
  output logic [7:0]                        wb_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]             wb_warpid_o,
  output logic                              wb_last_o,
  output logic [4:0]                        wb_fflags_o
);
  localparam int ELEMS = SHAPE_M * SHAPE_N;
  localparam int BEATS = ELEMS / NUM_THREAD;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [ELEMS-1:0][ELEM_W-1:0] data;
    logic [ELEMS-1:0][4:0]        fflags;
    logic [ELEMS-1:0]             mask;
    logic [7:0]                   reg_idxw;
    logic [DEPTH_WARP-1:0]        warpid;
  } tile_t;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  tile_t              tile_q, tile_in;
  logic               draining, last_beat;

  assign tile_in.data     = result_i;
  assign tile_in.fflags   = fflags_i;
  assign tile_in.mask     = elem_mask_i;
  assign tile_in.reg_idxw = reg_idxw_i;
  assign tile_in.warpid   = warpid_i;

  assign draining  = (state_q == DRAIN);
  assign last_beat = draining && (cnt_q == CNT_W'(BEATS - 1));
  // Ready re-opens on the last beat's handshake so a queued tile lands with no bubble.
  assign in_ready_o = !draining || (last_beat && wb_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tile_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            tile_q  <= tile_in;
            cnt_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (wb_ready_i) begin
            if (last_beat) begin
              cnt_q <= '0;
              if (in_valid_i) tile_q  <= tile_in;
              else            state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  logic [NUM_THREAD-1:0][ELEM_W-1:0] lane_data;
  logic [NUM_THREAD-1:0]             lane_mask;

  for (genvar l = 0; l < NUM_THREAD; l++) begin : g_lane
    tc_wb_lane #(
      .ELEMS(ELEMS), .ELEM_W(ELEM_W), .NUM_THREAD(NUM_THREAD), .CNT_W(CNT_W), .LANE(l)
    ) u_lane (
      .tile_data(tile_q.data),
      .tile_mask(tile_q.mask),
      .cnt      (cnt_q),
      .data     (lane_data[l]),
      .mask     (lane_mask[l])
    );
  end

  // Masked-off elements never contribute exception flags.
  logic [4:0] ff_acc;
  always_comb begin
    ff_acc = '0;
    for (int e = 0; e < ELEMS; e++)
      ff_acc |= tile_q.fflags[e] & {5{tile_q.mask[e]}};
  end

  assign wb_valid_o    = draining;
  assign wb_data_o     = draining ? lane_data : '0;
  assign wb_mask_o     = draining ? lane_mask : '0;
  assign wb_reg_idxw_o = draining ? tile_q.reg_idxw + 8'(cnt_q) : '0;
  assign wb_warpid_o   = draining ? tile_q.warpid : '0;
  assign wb_last_o     = last_beat;
  assign wb_fflags_o   = last_beat ? ff_acc : '0;
endmodule

// File: tb/tb_tc_result_writeback.sv
// Directed bench for tc_result_writeback: latency, backpressure, back-to-back,
// register wrap, masking/fflags, mid-drain reset and ignored upstream valid.

module tb_tc_result_writeback;
  localparam int E = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_i, in_ready_o;
  logic [511:0] result_i;
  logic [319:0] fflags_i;
  logic [63:0]  elem_mask_i;
  logic [7:0]   reg_idxw_i;
  logic [1:0]   warpid_i;
  logic         wb_valid_o, wb_ready_i;
  logic [63:0]  wb_data_o;
  logic [7:0]   wb_mask_o;
  logic [7:0]   wb_reg_idxw_o;
  logic [1:0]   wb_warpid_o;
  logic         wb_last_o;
  logic [4:0]   wb_fflags_o;

  always #5 clk = ~clk;

  tc_result_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .result_i(result_i), .fflags_i(fflags_i), .elem_mask_i(elem_mask_i),
    .reg_idxw_i(reg_idxw_i), .warpid_i(warpid_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_mask_o(wb_mask_o), .wb_reg_idxw_o(wb_reg_idxw_o),
    .wb_warpid_o(wb_warpid_o), .wb_last_o(wb_last_o), .wb_fflags_o(wb_fflags_o)
  );

  int checks = 0;
  int errors = 0;

  int         x_mul, x_add;
  logic [63:0] x_mask;
  logic [7:0]  x_base;
  logic [1:0]  x_warp;
  logic [4:0]  x_ff;
  bit          rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mul, input int add, input int e);
    return 8'(e * mul + add);
  endfunction

  task automatic drive_tile(input int mul, input int add, input logic [63:0] mask,
                            input logic [319:0] ff, input logic [7:0] base, input logic [1:0] warp);
    for (int e = 0; e < E; e++) result_i[e*8 +: 8] = pat(mul, add, e);
    fflags_i    = ff;
    elem_mask_i = mask;
    reg_idxw_i  = base;
    warpid_i    = warp;
  endtask

  task automatic set_exp(input int mul, input int add, input logic [63:0] mask,
                         input logic [7:0] base, input logic [1:0] warp, input logic [4:0] ff5);
    x_mul = mul; x_add = add; x_mask = mask; x_base = base; x_warp = warp; x_ff = ff5;
  endtask

  task automatic offer(input int mul, input int add, input logic [63:0] mask, input logic [319:0] ff,
                       input logic [7:0] base, input logic [1:0] warp, input logic [4:0] ff5);
    @(negedge clk);
    drive_tile(mul, add, mask, ff, base, warp);
    set_exp(mul, add, mask, base, warp, ff5);
    in_valid_i = 1'b1;
    wb_ready_i = 1'b1;
    #1;
    chk("accept_ready", 64'(in_ready_o), 64'(1));
    chk("accept_no_beat", 64'(wb_valid_o), 64'(0));
  endtask

  // Walks beats 0..stop-1 against the expected tile; mode 1 applies the 1,0,0,1 stall pattern.
  task automatic drain(input int mode, input bit keep_valid, input int stop);
    int k = 0;
    int cyc = 0;
    logic [63:0] ed;
    while (k < stop && cyc < 200) begin
      @(negedge clk);
      in_valid_i = keep_valid;
      wb_ready_i = (mode == 0) ? 1'b1 : rdy_pat[cyc % 4];
      cyc++;
      #1;
      for (int l = 0; l < 8; l++) ed[l*8 +: 8] = pat(x_mul, x_add, k*8 + l);
      chk("wb_valid",  64'(wb_valid_o), 64'(1));
      chk("wb_data",   wb_data_o, ed);
      chk("wb_mask",   64'(wb_mask_o), 64'(x_mask[k*8 +: 8]));
      chk("wb_reg",    64'(wb_reg_idxw_o), 64'(8'(x_base + k)));
      chk("wb_warp",   64'(wb_warpid_o), 64'(x_warp));
      chk("wb_last",   64'(wb_last_o), 64'(k == 7));
      chk("wb_fflags", 64'(wb_fflags_o), (k == 7) ? 64'(x_ff) : 64'(0));
      chk("in_ready",  64'(in_ready_o), 64'((k == 7) && wb_ready_i));
      if (wb_ready_i) k++;
    end
    chk("drain_beats", 64'(k), 64'(stop));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    in_valid_i = 1'b0;
    #1;
    chk({tag, "_valid"}, 64'(wb_valid_o), 64'(0));
    chk({tag, "_ready"}, 64'(in_ready_o), 64'(1));
  endtask

  logic [319:0] ff_wm;
  logic [63:0]  ed0;

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; wb_ready_i = 1'b0;
    result_i = '0; fflags_i = '0; elem_mask_i = '0; reg_idxw_i = '0; warpid_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid",  64'(wb_valid_o), 64'(0));
    chk("rst_ready",  64'(in_ready_o), 64'(1));
    chk("rst_data",   wb_data_o, 64'(0));
    chk("rst_mask",   64'(wb_mask_o), 64'(0));
    chk("rst_reg",    64'(wb_reg_idxw_o), 64'(0));
    chk("rst_warp",   64'(wb_warpid_o), 64'(0));
    chk("rst_last",   64'(wb_last_o), 64'(0));
    chk("rst_fflags", 64'(wb_fflags_o), 64'(0));

    // Basic tile: element e = e, regs 0x10..0x17
    offer(1, 0, '1, '0, 8'h10, 2'd2, 5'd0);
    drain(0, 1'b0, 8);
    idle_check("t1_end");

    // Backpressure
    offer(3, 7, '1, '0, 8'h30, 2'd1, 5'd0);
    drain(1, 1'b0, 8);
    idle_check("t2_end");

    // Back-to-back: tile 2 waits on the inputs while tile 1 drains
    offer(5, 1, '1, '0, 8'h18, 2'd3, 5'd0);
    @(posedge clk);
    #1;
    drive_tile(7, 2, '1, '0, 8'h20, 2'd0);
    drain(0, 1'b1, 8);
    set_exp(7, 2, '1, 8'h20, 2'd0, 5'd0);
    drain(0, 1'b0, 8);
    idle_check("t3_end");

    // Register wrap, masked beat 1, flag from masked element 9 suppressed
    ff_wm = '0;
    ff_wm[9*5 +: 5] = 5'b10000;
    ff_wm[3*5 +: 5] = 5'b00001;
    offer(2, 9, 64'hFFFF_FFFF_FFFF_00FF, ff_wm, 8'hFE, 2'd1, 5'b00001);
    drain(1, 1'b0, 8);
    idle_check("t4_end");

    // Reset after beat 3 is accepted
    offer(1, 100, '1, '0, 8'h40, 2'd2, 5'd0);
    drain(0, 1'b0, 4);
    @(negedge clk);
    rst = 1'b1; wb_ready_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(wb_valid_o), 64'(0));
    chk("midrst_ready", 64'(in_ready_o), 64'(1));
    chk("midrst_last",  64'(wb_last_o), 64'(0));
    offer(4, 3, '1, '0, 8'h60, 2'd3, 5'd0);
    drain(0, 1'b0, 8);
    idle_check("t5_end");

    // Upstream valid while not ready must be ignored
    offer(6, 5, '1, '0, 8'h50, 2'd1, 5'd0);
    for (int l = 0; l < 8; l++) ed0[l*8 +: 8] = pat(6, 5, l);
    repeat (3) begin
      @(negedge clk);
      wb_ready_i = 1'b0;
      drive_tile(9, 9, '0, '1, 8'hAA, 2'd0);
      in_valid_i = 1'b1;
      #1;
      chk("ign_ready", 64'(in_ready_o), 64'(0));
      chk("ign_reg",   64'(wb_reg_idxw_o), 64'(8'h50));
      chk("ign_data",  wb_data_o, ed0);
    end
    drain(0, 1'b0, 8);
    idle_check("t6_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tc_result_writeback.md
Name: tc_result_writeback

Overview:
- Receiving end of the tensor-core result interface: accepts one full SHAPE_M x SHAPE_N result tile plus control tags per valid/ready handshake.
- Serialises the tile into NUM_THREAD-lane beats for the vector register file write port.
- Each beat targets consecutive destination registers starting at the tile's reg_idxw.
- Sits between the tensor core array output and the writeback arbiter.

Parameters:
SHAPE_M, 8, result tile rows
SHAPE_N, 8, result tile columns
ELEM_W, 8, bits per result element (FP8 container)
NUM_THREAD, 8, lanes per writeback beat; must divide SHAPE_M*SHAPE_N
DEPTH_WARP, 2, warp id width
Derived: BEATS = SHAPE_M*SHAPE_N/NUM_THREAD (default 8); CNT_W = max(1, clog2(BEATS))

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid_i  in  1  tile valid from tensor core
in_ready_o  out  1  block can accept a tile
result_i  in  SHAPE_M*SHAPE_N*ELEM_W  tile; element e (=row*SHAPE_N+col) at [e*ELEM_W +: ELEM_W]
fflags_i  in  SHAPE_M*SHAPE_N*5  per-element exception flags, element e at [e*5 +: 5]
elem_mask_i  in  SHAPE_M*SHAPE_N  per-element write enable
reg_idxw_i  in  8  base destination register
warpid_i  in  DEPTH_WARP  warp tag
wb_valid_o  out  1  beat valid
wb_ready_i  in  1  arbiter accepts beat
wb_data_o  out  NUM_THREAD*ELEM_W  beat data, lane l = element beat*NUM_THREAD+l
wb_mask_o  out  NUM_THREAD  lane write enables
wb_reg_idxw_o  out  8  destination register for this beat
wb_warpid_o  out  DEPTH_WARP  warp tag
wb_last_o  out  1  final beat of tile
wb_fflags_o  out  5  OR of fflags over unmasked elements of the whole tile; nonzero only when wb_last_o=1

Behaviour:
- States: IDLE, DRAIN.
- Reset (rst=1 at posedge): state=IDLE, beat counter=0, all wb_* outputs 0, in_ready_o=1 in the following cycle.
- Reset mid-DRAIN discards the buffered tile; no further beats are emitted.
- IDLE:
  - in_ready_o=1; wb_valid_o=0.
  - On in_valid_i && in_ready_o: register result_i, fflags_i, elem_mask_i, reg_idxw_i, warpid_i; clear counter; go to DRAIN.
- DRAIN:
  - wb_valid_o=1 every cycle from the cycle after capture (capture-to-first-beat latency 1 cycle).
  - wb_data_o, wb_mask_o: slice selected by the counter.
  - wb_reg_idxw_o = stored base + counter, modulo 256 (wraps, e.g. 0xFE+3 = 0x01).
  - wb_last_o = (counter == BEATS-1).
  - Outputs hold stable while wb_valid_o && !wb_ready_i (no retraction, no data change).
  - wb_valid_o && wb_ready_i and not last: counter += 1.
  - Last beat accepted: counter -> 0.
    - If in_valid_i in the same cycle: capture the new tile and stay in DRAIN (back-to-back, zero bubble).
    - Otherwise: go to IDLE.
- in_ready_o = (state==IDLE) || (wb_last_o && wb_ready_i). The second term is a combinational path from wb_ready_i; no other combinational input-to-output paths.
- Fully masked beats (wb_mask_o == 0) are still emitted and consume a handshake, so beat count per tile is always BEATS.
- wb_fflags_o: computed from the registered copy.
  - Per-element flags are gated by the element's mask bit, then ORed.
  - Driven only on the last beat; 0 on all other beats.
- in_valid_i while in_ready_o=0 is ignored; the upstream holds its data.

Test Plan:
- Reset, then tile with element e = e, all mask=1, reg_idxw=0x10, warpid=2, wb_ready_i=1 -> 8 beats on consecutive cycles starting 1 cycle after accept; beat k lane l = 8k+l; reg_idxw 0x10..0x17; wb_last_o only on beat 7; in_ready_o=0 during beats 0-6.
- Backpressure: wb_ready_i toggles 1,0,0,1,... -> each beat is held unchanged while stalled; total 8 accepted beats in order; no beat duplicated or dropped.
- Back-to-back: second tile (reg_idxw=0x20) is valid while tile 1 is draining -> it is accepted in the cycle tile 1's beat 7 completes; its beat 0 (reg 0x20) follows on the next cycle with no idle cycle.
- Wrap and mask: reg_idxw=0xFE; elem_mask clears elements 8-15; fflags of element 9 = 5'b10000 and element 3 = 5'b00001 -> regs 0xFE,0xFF,0x00..0x05; beat 1 mask=0x00 but still handshaked; wb_fflags_o=5'b00001 on last beat only.
- Reset asserted after beat 3 is accepted -> the cycle after reset has wb_valid_o=0 and in_ready_o=1; a new tile restarts at beat 0 with the new reg_idxw.
- in_valid_i pulsed during DRAIN without a last-beat handshake -> ignored; the buffered tile's data is unchanged.
